// File: rtl/lc3_mio_arbiter.sv
// lc3_mio_arbiter: two-port (CPU / debug) arbiter and transaction sequencer
// in front of the LC-3 memory/IO address controller. One access at a time,
// round-robin on ties, MIO_EN forced low for DONE + IDLE between accesses.
// Optional feature macro: LC3_MIO_ARB_TIMEOUT_EN (abort an access that sees
// no ready pulse within TIMEOUT cycles and report it on ERR).
module lc3_mio_arbiter #(
  parameter int TIMEOUT = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        CPU_REQ,
  input  logic        CPU_WE,
  input  logic [15:0] CPU_ADDR,
  input  logic [15:0] CPU_WDATA,
  output logic        CPU_ACK,
  output logic [15:0] CPU_RDATA,
  output logic        CPU_ERR,
  input  logic        DBG_REQ,
  input  logic        DBG_WE,
  input  logic [15:0] DBG_ADDR,
  input  logic [15:0] DBG_WDATA,
  output logic        DBG_ACK,
  output logic [15:0] DBG_RDATA,
  output logic        DBG_ERR,
  output logic        MIO_EN,
  output logic        R_W,
  output logic [15:0] ADDR,
  output logic [15:0] MIO_WDATA,
  input  logic [15:0] MIO_RDATA,
  input  logic        R,
  output logic        BUSY,
  output logic        OWNER
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t state;
  logic   grant_dbg;

  // Legal TIMEOUT is 2..63; this empty block names an illegal setting in the
  // elaborated hierarchy so it shows up in any netlist review.
  if ((TIMEOUT < 2) || (TIMEOUT > 63)) begin : g_timeout_out_of_range
  end

`ifdef LC3_MIO_ARB_TIMEOUT_EN
  localparam logic [5:0] WAIT_LAST = 6'(TIMEOUT - 1);
  logic [5:0] wait_cnt;
`else
  assign CPU_ERR = 1'b0;
  assign DBG_ERR = 1'b0;
`endif

  // Winner selection: a lone requester wins; on a tie the port that did not
  // own the previous transaction wins.
  always_comb begin
    grant_dbg = DBG_REQ;
    if (CPU_REQ && DBG_REQ) begin
      grant_dbg = ~OWNER;
    end
  end

  // Sequencer: IDLE -> ACCESS (MIO_EN high) -> DONE (ACK pulse) -> IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      MIO_EN    <= 1'b0;
      R_W       <= 1'b0;
      ADDR      <= 16'h0000;
      MIO_WDATA <= 16'h0000;
      BUSY      <= 1'b0;
      OWNER     <= 1'b1;
      CPU_ACK   <= 1'b0;
      DBG_ACK   <= 1'b0;
      CPU_RDATA <= 16'h0000;
      DBG_RDATA <= 16'h0000;
`ifdef LC3_MIO_ARB_TIMEOUT_EN
      CPU_ERR   <= 1'b0;
      DBG_ERR   <= 1'b0;
      wait_cnt  <= 6'd0;
`endif
    end else begin
      // Acknowledge and error are single-cycle pulses.
      CPU_ACK <= 1'b0;
      DBG_ACK <= 1'b0;
`ifdef LC3_MIO_ARB_TIMEOUT_EN
      CPU_ERR <= 1'b0;
      DBG_ERR <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (CPU_REQ || DBG_REQ) begin
            OWNER     <= grant_dbg;
            R_W       <= grant_dbg ? DBG_WE    : CPU_WE;
            ADDR      <= grant_dbg ? DBG_ADDR  : CPU_ADDR;
            MIO_WDATA <= grant_dbg ? DBG_WDATA : CPU_WDATA;
            MIO_EN    <= 1'b1;
            BUSY      <= 1'b1;
            state     <= ACCESS;
`ifdef LC3_MIO_ARB_TIMEOUT_EN
            wait_cnt  <= 6'd0;
`endif
          end
        end
        ACCESS: begin
          if (R) begin
            // Ready wins over a coincident timeout.
            MIO_EN <= 1'b0;
            state  <= DONE;
            if (OWNER) begin
              DBG_ACK <= 1'b1;
              if (!R_W) DBG_RDATA <= MIO_RDATA;
            end else begin
              CPU_ACK <= 1'b1;
              if (!R_W) CPU_RDATA <= MIO_RDATA;
            end
          end
`ifdef LC3_MIO_ARB_TIMEOUT_EN
          else if (wait_cnt == WAIT_LAST) begin
            MIO_EN <= 1'b0;
            state  <= DONE;
            if (OWNER) begin
              DBG_ACK <= 1'b1;
              DBG_ERR <= 1'b1;
              if (!R_W) DBG_RDATA <= 16'h0000;
            end else begin
              CPU_ACK <= 1'b1;
              CPU_ERR <= 1'b1;
              if (!R_W) CPU_RDATA <= 16'h0000;
            end
          end else begin
            wait_cnt <= wait_cnt + 6'd1;
          end
`endif
        end
        DONE: begin
          BUSY  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          MIO_EN <= 1'b0;
          BUSY   <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lc3_mio_arbiter.sv
// Testbench for lc3_mio_arbiter: directed vector table, hand-written corner
// sequences (timeout, async reset mid-access, R outside ACCESS) and random
// transactions checked against a transaction-level model of the arbiter.
module tb_lc3_mio_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        CPU_REQ, CPU_WE, DBG_REQ, DBG_WE, R;
  logic [15:0] CPU_ADDR, CPU_WDATA, DBG_ADDR, DBG_WDATA, MIO_RDATA;
  logic        CPU_ACK, CPU_ERR, DBG_ACK, DBG_ERR, MIO_EN, R_W, BUSY, OWNER;
  logic [15:0] CPU_RDATA, DBG_RDATA, ADDR, MIO_WDATA;

  always #5 clk = ~clk;

  lc3_mio_arbiter #(.TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .CPU_REQ(CPU_REQ), .CPU_WE(CPU_WE), .CPU_ADDR(CPU_ADDR), .CPU_WDATA(CPU_WDATA),
    .CPU_ACK(CPU_ACK), .CPU_RDATA(CPU_RDATA), .CPU_ERR(CPU_ERR),
    .DBG_REQ(DBG_REQ), .DBG_WE(DBG_WE), .DBG_ADDR(DBG_ADDR), .DBG_WDATA(DBG_WDATA),
    .DBG_ACK(DBG_ACK), .DBG_RDATA(DBG_RDATA), .DBG_ERR(DBG_ERR),
    .MIO_EN(MIO_EN), .R_W(R_W), .ADDR(ADDR), .MIO_WDATA(MIO_WDATA),
    .MIO_RDATA(MIO_RDATA), .R(R), .BUSY(BUSY), .OWNER(OWNER)
  );

  typedef struct {
    bit          creq, dreq, cwe, dwe;
    logic [15:0] caddr, daddr, cwd, dwd;
    int          r_lat;   // R seen this many cycles after MIO_EN rises
    logic [15:0] rd;
    bit          drop;    // requester releases REQ during ACCESS
  } txn_t;

  int n_vec = 0;
  int n_err = 0;

  // Transaction-level model: last owner and each port's visible read data.
  bit          m_owner;
  logic [15:0] m_crd, m_drd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = 1'b1;
    m_crd   = 16'h0000;
    m_drd   = 16'h0000;
  endtask

  task automatic clear_inputs();
    CPU_REQ = 0; CPU_WE = 0; CPU_ADDR = 0; CPU_WDATA = 0;
    DBG_REQ = 0; DBG_WE = 0; DBG_ADDR = 0; DBG_WDATA = 0;
    R = 0; MIO_RDATA = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  function automatic txn_t mk(bit creq, bit dreq, bit cwe, bit dwe,
                              logic [15:0] caddr, logic [15:0] daddr,
                              logic [15:0] cwd, logic [15:0] dwd,
                              int r_lat, logic [15:0] rd, bit drop);
    txn_t t;
    t.creq = creq; t.dreq = dreq; t.cwe = cwe; t.dwe = dwe;
    t.caddr = caddr; t.daddr = daddr; t.cwd = cwd; t.dwd = dwd;
    t.r_lat = r_lat; t.rd = rd; t.drop = drop;
    return t;
  endfunction

  // One complete access: request, wait r_lat cycles for R, ACK, back to IDLE.
  task automatic run_txn(input txn_t t);
    bit          win, we, ok;
    logic [15:0] a, wd;
    win = (t.creq && t.dreq) ? !m_owner : t.dreq;
    we  = win ? t.dwe   : t.cwe;
    a   = win ? t.daddr : t.caddr;
    wd  = win ? t.dwd   : t.cwd;
    @(negedge clk);
    CPU_REQ = t.creq; CPU_WE = t.cwe; CPU_ADDR = t.caddr; CPU_WDATA = t.cwd;
    DBG_REQ = t.dreq; DBG_WE = t.dwe; DBG_ADDR = t.daddr; DBG_WDATA = t.dwd;
    R = 0;
    @(posedge clk); #1;
    chk("grant_mio_en", MIO_EN, 1);
    chk("grant_owner", OWNER, win);
    chk("grant_addr", ADDR, a);
    chk("grant_rw", R_W, we);
    if (we) chk("grant_wdata", MIO_WDATA, wd);
    chk("grant_busy", BUSY, 1);
    m_owner = win;
    ok = 1;
    for (int i = 1; i < t.r_lat; i++) begin
      @(negedge clk);
      if (t.drop) begin CPU_REQ = 0; DBG_REQ = 0; end
      CPU_ADDR = 16'($urandom); DBG_ADDR = 16'($urandom);
      @(posedge clk); #1;
      if (MIO_EN !== 1'b1 || CPU_ACK !== 1'b0 || DBG_ACK !== 1'b0 ||
          ADDR !== a || R_W !== we) ok = 0;
    end
    chk("access_hold", ok, 1);
    @(negedge clk);
    R = 1; MIO_RDATA = t.rd;
    @(posedge clk); #1;
    if (!we) begin
      if (win) m_drd = t.rd; else m_crd = t.rd;
    end
    chk("done_cpu_ack", CPU_ACK, !win);
    chk("done_dbg_ack", DBG_ACK, win);
    chk("done_mio_en", MIO_EN, 0);
    chk("done_cpu_rdata", CPU_RDATA, m_crd);
    chk("done_dbg_rdata", DBG_RDATA, m_drd);
    chk("done_err", {CPU_ERR, DBG_ERR}, 0);
    @(negedge clk);
    R = 0; CPU_REQ = 0; DBG_REQ = 0; MIO_RDATA = 16'($urandom);
    @(posedge clk); #1;
    chk("idle_acks", {CPU_ACK, DBG_ACK}, 0);
    chk("idle_mio_en", MIO_EN, 0);
    chk("idle_busy", BUSY, 0);
    chk("idle_rdata", {CPU_RDATA, DBG_RDATA}, {m_crd, m_drd});
  endtask

  txn_t vec[6];

  initial begin
    vec[0] = mk(1, 0, 0, 0, 16'h3000, 16'h1111, 16'h0000, 16'h0000, 2, 16'hBEEF, 0);
    vec[1] = mk(0, 1, 0, 1, 16'h2222, 16'hFE06, 16'h0000, 16'h0041, 1, 16'h5A5A, 0);
    vec[2] = mk(1, 1, 0, 0, 16'h4000, 16'h5000, 16'h0001, 16'h0002, 3, 16'hA001, 0);
    vec[3] = mk(1, 1, 0, 0, 16'h4001, 16'h5001, 16'h0003, 16'h0004, 1, 16'hA002, 0);
    vec[4] = mk(1, 1, 1, 0, 16'h4002, 16'h5002, 16'hC0DE, 16'h0006, 2, 16'hA003, 0);
    vec[5] = mk(1, 1, 0, 1, 16'h4003, 16'h5003, 16'h0007, 16'hF00D, 4, 16'hA004, 1);

    do_reset();
    #1;
    chk("rst_mio_en", MIO_EN, 0);
    chk("rst_busy_rw", {BUSY, R_W}, 0);
    chk("rst_owner", OWNER, 1);
    chk("rst_acks_errs", {CPU_ACK, DBG_ACK, CPU_ERR, DBG_ERR}, 0);
    chk("rst_addr_wdata", {ADDR, MIO_WDATA}, 0);
    chk("rst_rdata", {CPU_RDATA, DBG_RDATA}, 0);

    // Directed table: CPU read, DBG write, then four tied requests.
    for (int i = 0; i < 6; i++) run_txn(vec[i]);

    // R pulsing while nothing is in flight must be ignored.
    @(negedge clk); R = 1; MIO_RDATA = 16'hDEAD;
    @(posedge clk); #1;
    chk("stray_r_mio_en", MIO_EN, 0);
    chk("stray_r_acks", {CPU_ACK, DBG_ACK}, 0);
    chk("stray_r_rdata", {CPU_RDATA, DBG_RDATA}, {m_crd, m_drd});
    @(negedge clk); R = 0;

`ifdef LC3_MIO_ARB_TIMEOUT_EN
    // R coinciding with the timeout threshold: R wins, no error.
    run_txn(mk(1, 0, 0, 0, 16'h0123, 16'h0000, 16'h0000, 16'h0000, 8, 16'h1234, 0));
    // No R at all: abort exactly 8 cycles after MIO_EN rises.
    begin
      int cyc;
      @(negedge clk); CPU_REQ = 1; CPU_WE = 0; CPU_ADDR = 16'h0777; DBG_REQ = 0;
      @(posedge clk); #1;
      chk("to_mio_en", MIO_EN, 1);
      cyc = 0;
      while (cyc < 20) begin
        @(posedge clk); #1;
        cyc++;
        if (CPU_ACK === 1'b1) break;
      end
      m_owner = 0; m_crd = 16'h0000;
      chk("to_latency", cyc, 8);
      chk("to_err", {CPU_ACK, CPU_ERR, DBG_ACK, DBG_ERR}, 4'b1100);
      chk("to_rdata", CPU_RDATA, m_crd);
      chk("to_mio_en_low", MIO_EN, 0);
      @(negedge clk); CPU_REQ = 0;
      @(posedge clk); #1;
      chk("to_pulse_end", {CPU_ACK, CPU_ERR}, 0);
    end
`else
    // Without the timeout feature an access waits for R indefinitely.
    begin
      bit ok;
      @(negedge clk); CPU_REQ = 1; CPU_WE = 0; CPU_ADDR = 16'h0777; DBG_REQ = 0;
      ok = 1;
      for (int i = 0; i < 100; i++) begin
        @(posedge clk); #1;
        if (MIO_EN !== 1'b1 || CPU_ACK !== 1'b0 || CPU_ERR !== 1'b0) ok = 0;
      end
      chk("no_timeout_wait", ok, 1);
      do_reset();
    end
`endif

    // Async reset in cycle 2 of ACCESS drops the transaction immediately.
    @(negedge clk); CPU_REQ = 1; CPU_WE = 0; CPU_ADDR = 16'h0ABC; DBG_REQ = 0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk); #2;
    rst_n = 0;
    clear_inputs();
    #1;
    chk("arst_mio_en", MIO_EN, 0);
    chk("arst_acks", {CPU_ACK, DBG_ACK}, 0);
    chk("arst_owner", OWNER, 1);
    model_reset();
    @(negedge clk); rst_n = 1;
    run_txn(mk(1, 1, 0, 0, 16'h1000, 16'h2000, 16'h0, 16'h0, 2, 16'h7777, 0));

    // Random traffic against the model.
    for (int n = 0; n < 40; n++) begin
      txn_t t;
      int   sel;
      sel = $urandom_range(2, 0);
`ifdef LC3_MIO_ARB_TIMEOUT_EN
      t = mk(sel != 1, sel != 0, 1'($urandom), 1'($urandom),
             16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
             $urandom_range(7, 1), 16'($urandom), 1'($urandom));
`else
      t = mk(sel != 1, sel != 0, 1'($urandom), 1'($urandom),
             16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
             $urandom_range(12, 1), 16'($urandom), 1'($urandom));
`endif
      run_txn(t);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lc3_mio_arbiter.md
# lc3_mio_arbiter

Two-port arbiter and transaction sequencer in front of the LC-3 memory/IO address controller. It shares one MIO access path between the CPU memory interface and the debug/loader port. It drives `MIO_EN`, `R_W`, `ADDR` and write data to the address decoder, waits for the ready pulse `R`, then returns read data and a one-cycle acknowledge to the winning requester. It guarantees `MIO_EN` drops between transactions, so the decoder's ready sequencer restarts cleanly every access.

## Interface
Parameters:
- `TIMEOUT`, default 32: cycles in ACCESS without `R` before abort. Legal range 2..63.

Ports (one clock; reset is asynchronous, active-low):
- `clk`  in  1  rising-edge system clock
- `rst_n`  in  1  async active-low reset
- `CPU_REQ`  in  1  CPU request; level, held until `CPU_ACK`
- `CPU_WE`  in  1  1 = write, 0 = read
- `CPU_ADDR`  in  16  CPU address
- `CPU_WDATA`  in  16  CPU write data
- `CPU_ACK`  out  1  one-cycle completion pulse
- `CPU_RDATA`  out  16  read data, valid during `CPU_ACK`
- `CPU_ERR`  out  1  timeout flag, valid during `CPU_ACK`
- `DBG_REQ`, `DBG_WE`, `DBG_ADDR`, `DBG_WDATA`, `DBG_ACK`, `DBG_RDATA`, `DBG_ERR`: same as the CPU set, for the debug/loader port
- `MIO_EN`  out  1  access enable to the address controller
- `R_W`  out  1  1 = write, 0 = read
- `ADDR`  out  16  access address
- `MIO_WDATA`  out  16  write data
- `MIO_RDATA`  in  16  read data from the memory/IO mux
- `R`  in  1  ready pulse from the address controller
- `BUSY`  out  1  high in ACCESS and DONE
- `OWNER`  out  1  0 = CPU, 1 = DBG; owner of the current or last transaction

## Operation
- States: IDLE, ACCESS, DONE. All outputs are registered.
- Reset values: state IDLE; `MIO_EN`, `R_W`, `BUSY`, all ACK and ERR outputs 0; `ADDR`, `MIO_WDATA`, both RDATA outputs 16'h0000; `OWNER`=1, so the CPU wins the first tie.
- IDLE:
  - Any REQ high: pick a winner, latch its WE/ADDR/WDATA into `R_W`/`ADDR`/`MIO_WDATA`, set `OWNER`, assert `MIO_EN`, go to ACCESS.
  - Single request: it wins.
  - Both requesting: round-robin; the winner is the port not equal to `OWNER`.
- ACCESS:
  - `MIO_EN` stays high; address, data and direction stay stable. The 6-bit wait counter increments each cycle.
  - On `R`=1: capture `MIO_RDATA` into the owner's RDATA (reads only; writes leave RDATA unchanged), drop `MIO_EN`, go to DONE with owner ACK=1 and ERR=0.
- DONE: the ACK/ERR pulse is visible for exactly this cycle. `MIO_EN`=0. Go to IDLE.
- The non-owner's ACK/ERR/RDATA never change.
- Requester deasserting REQ mid-ACCESS: ignored; the transaction completes and ACK is still issued.
- `R` outside ACCESS: ignored.
- Requester must drop REQ in the cycle after ACK, or it is treated as a new request in IDLE.

## Timing
- REQ sampled high in IDLE at edge N: `MIO_EN`=1 after edge N.
- `R` seen at edge M: ACK=1 and `MIO_EN`=0 after edge M, ACK=0 after M+1, IDLE after M+1.
- `MIO_EN` is low for at least 2 cycles (DONE + IDLE) between back-to-back transactions.
- Request-to-ACK latency = decoder ready latency + 1 cycle.
- Wait counter clears on entry to ACCESS.
- `R` and timeout in the same cycle: `R` wins and ERR=0.
- Async reset mid-ACCESS: `MIO_EN` low immediately, no ACK issued, in-flight transaction dropped.

## Configuration
- `LC3_MIO_ARB_TIMEOUT_EN` defined:
  - In ACCESS, when the counter reaches `TIMEOUT`-1 with `R`=0, abort to DONE with ACK=1 and ERR=1.
  - Owner RDATA becomes 16'h0000 on an aborted read.
- Undefined: no counter logic. ACCESS waits for `R` indefinitely; both ERR outputs are tied 0.

## Test plan
- CPU read of 16'h3000 with `R` returned 2 cycles after `MIO_EN` rises and `MIO_RDATA`=16'hBEEF -> `ADDR`=16'h3000, `R_W`=0, `CPU_ACK` pulses 1 cycle with `CPU_RDATA`=16'hBEEF, `DBG_ACK` stays 0.
- DBG write 16'h0041 to 16'hFE06 with `R` after 1 cycle -> `R_W`=1, `MIO_WDATA`=16'h0041, `DBG_ACK` pulse, `OWNER`=1.
- Both REQ held high for 4 transactions after reset -> grant order CPU, DBG, CPU, DBG; `MIO_EN` low for at least 2 cycles between each.
- With macro, `TIMEOUT`=8, `R` never asserted -> ACK+ERR pulse exactly 8 cycles after `MIO_EN` rises, RDATA=16'h0000. Without macro -> `MIO_EN` held high for 100 cycles, no ACK.
- `rst_n` low in cycle 2 of ACCESS -> `MIO_EN`=0 asynchronously, no ACK. After release, a pending CPU REQ is granted first.
- `R` in the same cycle as the timeout threshold (macro on) -> ERR=0 and RDATA equals `MIO_RDATA`.
